mult_rr_scheduler: RTL and testbench
====================================

// Module: mult_rr_scheduler
// PURPOSE
//  Shares one pipelined signed WIDTHxWIDTH multiplier between NUM_REQ requesters.
//  Round-robin arbitration; valid/ready handshakes on every request port and on
//  the single response port. Each result carries the ID of the requester that
//  issued it. Stages hold on response back-pressure, using the same global-enable
//  idiom as the existing registered multiplier wrapper.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..16)
//  WIDTH     32   operand width, signed two's complement
//  LATENCY   2    accept-to-response cycles (>=2): input register, LATENCY-2 middle stages, output register
// PORTS
//  clk          in   1                clock, all state on rising edge
//  reset        in   1                synchronous, active-high
//  req_valid    in   NUM_REQ          requester i presents operands
//  req_ready    out  NUM_REQ          one-hot; requester i accepted this cycle
//  req_a        in   NUM_REQ*WIDTH    multiplicand, requester i at [i*WIDTH +: WIDTH]
//  req_b        in   NUM_REQ*WIDTH    multiplier, same packing
//  rsp_valid    out  1                result valid
//  rsp_ready    in   1                downstream accepts result
//  rsp_id       out  clog2(NUM_REQ)   requester index of this result
//  rsp_result   out  2*WIDTH          signed product
//  inflight     out  clog2(LATENCY+1) valid transactions held in the pipeline, including the output stage
// BEHAVIOUR
//  - Reset: rr_ptr=0; all stage valid bits=0; rsp_valid=0, rsp_id=0, rsp_result=0,
//    inflight=0; req_ready=0 during reset. Reset mid-operation drops all in-flight work.
//  - advance = !rsp_valid | rsp_ready. When advance=0, every stage holds, including
//    valid bits, data and ID. No request is accepted.
//  - Grant: the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    req_ready[i] = grant[i] & advance (combinational). At most one bit is set.
//  - Accept at cycle T (req_valid[i] & req_ready[i]): operands and ID are captured into
//    stage 1. rr_ptr <= (i+1) mod NUM_REQ at T+1. rr_ptr is unchanged if nothing is accepted.
//  - Without stalls, rsp_valid rises at T+LATENCY with product = $signed(a)*$signed(b),
//    full 2*WIDTH bits and no truncation. Each stall cycle adds one cycle.
//  - Throughput: one accept per cycle while advance=1. Bubbles propagate as valid=0 stages.
//  - rsp_valid/rsp_id/rsp_result hold stable while rsp_valid & !rsp_ready.
//  - Same-cycle accept and response retire are legal. inflight = popcount(stage valids).
//  - Requests are not required to stay valid. A requester that deasserts req_valid
//    before acceptance loses nothing, because no state is held for it.
//  - Results return in issue order. No reordering.
//  - Corner operands: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), which is representable and must not overflow.
// STRUCTURE
//  - Shared package mult_pkg: WIDTH default, ID_W = $clog2(NUM_REQ), and a response struct
//    {valid, id, result}.
//  - Sub-module rr_arbiter (NUM_REQ): inputs req and ptr; output one-hot grant and the
//    encoded index. Purely combinational, with rr_ptr held in the parent.
//  - The parent holds rr_ptr, the enable-gated stage registers (data, ID, valid), and the
//    multiply placed between stage 1 and stage 2.
// TESTING
//  1 Only req 2 valid, a=7, b=-3 at T -> req_ready=4'b0100 at T; at T+2 rsp_valid=1, id=2, result=-21.
//  2 All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id in the same order.
//  3 rr_ptr=1 and only reqs 0 and 3 valid -> grant 3 first, then 0.
//  4 rsp_ready=0 for 3 cycles while the pipe is full -> req_ready=0, rsp outputs frozen,
//    inflight=2; after release, results are in order with none lost or duplicated.
//  5 a=b=-2^31 (WIDTH=32) -> result=64'h4000_0000_0000_0000. a=-1, b=2^31-1 -> -(2^31-1).
//  6 reset pulsed with 2 in flight -> next cycle rsp_valid=0, inflight=0, rr_ptr=0;
//    the first post-reset request gets correct latency.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared defaults and response record for the multiplier scheduler
package mult_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 32;
  localparam int ID_W = $clog2(DEF_NUM_REQ);
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
    logic signed [2*DEF_WIDTH-1:0] result;
  } rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from ptr upward with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_BITS-1:0] idx
);
  logic found;
  int j;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      j = (int'(ptr) + o) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = ID_BITS'(j);
      end
    end
  end
endmodule

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin sharing of one pipelined signed multiplier
module mult_rr_scheduler
  import mult_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int LATENCY = 2,
  parameter int ID_BITS = $clog2(NUM_REQ),
  parameter int CNT_BITS = $clog2(LATENCY + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_BITS-1:0]         rsp_id,
  output logic [2*WIDTH-1:0]         rsp_result,
  output logic [CNT_BITS-1:0]        inflight
);
  logic [ID_BITS-1:0] rr_ptr, gidx;
  logic [NUM_REQ-1:0] grant;
  logic [LATENCY-1:0] v;
  logic [ID_BITS-1:0] id_r [LATENCY];
  logic signed [WIDTH-1:0] a_r, b_r;
  logic signed [2*WIDTH-1:0] p [1:LATENCY-1];
  logic advance, accept;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .grant(grant), .idx(gidx)
  );
  assign rsp_valid = v[LATENCY-1];
  assign rsp_id = id_r[LATENCY-1];
  assign rsp_result = p[LATENCY-1];
  assign advance = !rsp_valid || rsp_ready;
  assign req_ready = reset ? '0 : grant & {NUM_REQ{advance}};
  assign accept = |req_ready;
  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++) inflight = inflight + CNT_BITS'(v[k]);
  end
  // One global enable: a stalled output freezes every stage so order and data are kept.
  always_ff @(posedge clk)
    if (reset) begin
      v <= '0;
      rr_ptr <= '0;
      a_r <= '0;
      b_r <= '0;
      for (int k = 0; k < LATENCY; k++) id_r[k] <= '0;
      for (int k = 1; k < LATENCY; k++) p[k] <= '0;
    end else if (advance) begin
      v <= {v[LATENCY-2:0], accept};
      a_r <= req_a[int'(gidx)*WIDTH +: WIDTH];
      b_r <= req_b[int'(gidx)*WIDTH +: WIDTH];
      id_r[0] <= gidx;
      p[1] <= (2*WIDTH)'(a_r) * (2*WIDTH)'(b_r);
      for (int k = 1; k < LATENCY; k++) id_r[k] <= id_r[k-1];
      for (int k = 2; k < LATENCY; k++) p[k] <= p[k-1];
      if (accept) rr_ptr <= (gidx == ID_BITS'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: directed and random traffic against a transaction-queue model
module tb_mult_rr_scheduler;
  import mult_pkg::*;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 2;
  logic clk = 1'b0, reset = 1'b1, rsp_valid, rsp_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [1:0] rsp_id;
  logic [2*W-1:0] rsp_result;
  logic [1:0] inflight;
  int total = 0, bad = 0, ptr = 0;
  typedef struct {int id; longint prod; int rem;} txn_t;
  txn_t q[$];
  rsp_t obs;

  mult_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .inflight(inflight)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock: drive, compare against the model, then advance the model across the edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic rr);
    int g;
    logic adv, ev;
    txn_t t;
    req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    #1;
    obs = {rsp_valid, rsp_id, rsp_result};
    ev = q.size() > 0 && q[0].rem == 0;
    chk("rsp_valid", 64'(obs.valid), 64'(ev));
    if (ev) begin
      chk("rsp_id", 64'(obs.id), 64'(q[0].id));
      chk("rsp_result", obs.result, q[0].prod);
    end
    chk("inflight", 64'(inflight), 64'(q.size()));
    adv = !ev || rr;
    g = -1;
    for (int o = 0; o < N; o++) if (g < 0 && v[(ptr + o) % N]) g = (ptr + o) % N;
    chk("req_ready", 64'(req_ready), (adv && g >= 0) ? 64'(1 << g) : 64'd0);
    if (adv) begin
      if (ev) void'(q.pop_front());
      foreach (q[k]) if (q[k].rem > 0) q[k].rem--;
      if (g >= 0) begin
        t.id = g;
        t.prod = longint'($signed(a[g*W +: W])) * longint'($signed(b[g*W +: W]));
        t.rem = L - 1;
        q.push_back(t);
        ptr = (g + 1) % N;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_cycle(input logic rr);
    logic [N*W-1:0] a, b;
    for (int i = 0; i < N; i++) begin
      a[i*W +: W] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b[i*W +: W] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
    end
    cycle(N'($urandom), a, b, rr);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req_valid = '1; rsp_ready = 1'b1;
    #1;
    chk("req_ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_inflight", 64'(inflight), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_result", rsp_result, 64'd0);
    reset = 1'b0;
    q.delete();
    ptr = 0;
  endtask

  logic [N*W-1:0] opa, opb;
  initial begin
    @(posedge clk); #1;
    pulse_reset();
    opa = '0; opb = '0;
    opa[2*W +: W] = 32'd7; opb[2*W +: W] = -32'sd3;
    cycle(4'b0100, opa, opb, 1'b1);
    cycle(4'b0000, '0, '0, 1'b1);
    chk("t1_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFEB);
    cycle(4'b0000, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) rand_cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, '0, '0, 1'b1);
    opa = {32'd4, 32'd3, 32'd2, 32'd1}; opb = {32'd40, 32'd30, 32'd20, 32'd10};
    for (int i = 0; i < 5; i++) cycle(4'b1111, opa, opb, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, '0, '0, 1'b1);
    cycle(4'b0001, opa, opb, 1'b1);
    cycle(4'b1001, opa, opb, 1'b1);
    cycle(4'b1001, opa, opb, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b1111, opa, opb, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b1111, opa, opb, 1'b0);
    chk("t4_inflight_full", 64'(inflight), 64'd2);
    for (int i = 0; i < 4; i++) cycle(4'b0000, '0, '0, 1'b1);
    opa = '0; opb = '0;
    opa[W-1:0] = 32'h8000_0000; opb[W-1:0] = 32'h8000_0000;
    opa[2*W-1:W] = 32'hFFFF_FFFF; opb[2*W-1:W] = 32'h7FFF_FFFF;
    cycle(4'b0001, opa, opb, 1'b1);
    cycle(4'b0010, opa, opb, 1'b1);
    chk("t5_min_squared", rsp_result, 64'h4000_0000_0000_0000);
    cycle(4'b0000, '0, '0, 1'b1);
    chk("t5_neg_max", rsp_result, 64'hFFFF_FFFF_8000_0001);
    cycle(4'b0000, '0, '0, 1'b1);
    cycle(4'b1111, opa, opb, 1'b1);
    cycle(4'b1111, opa, opb, 1'b0);
    pulse_reset();
    opa = '0; opb = '0;
    opa[3*W +: W] = 32'd9; opb[3*W +: W] = 32'd11;
    cycle(4'b1000, opa, opb, 1'b1);
    cycle(4'b0000, '0, '0, 1'b1);
    chk("t6_post_reset", rsp_result, 64'd99);
    for (int i = 0; i < 300; i++) rand_cycle($urandom_range(0, 3) != 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(4'b0000, '0, '0, 1'b1);
    chk("drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
